skip_add_seq: RTL and testbench

SKIP_ADD_SEQ -- requirements
Module: skip_add_seq

---
 rtl/skip_add_seq_pkg.sv | 13 +
 rtl/skip_slice8.sv | 42 ++++
 rtl/skip_add_seq.sv | 118 +++++++++++
 tb/tb_skip_add_seq.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/skip_add_seq_pkg.sv
// Shared types and constants for the byte-serial carry-skip adder.
package skip_add_seq_pkg;

   localparam int unsigned SLICE_W = 8;
   localparam int unsigned NREQ    = 2;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

endpackage

// File: rtl/skip_slice8.sv
// 8-bit combinational adder built from two 4-bit carry-skip groups.
module skip_slice8
   import skip_add_seq_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               ci,
   output logic [SLICE_W-1:0] s,
   output logic               co
);

   localparam int unsigned GRP_W = 4;
   localparam int unsigned NGRP  = SLICE_W / GRP_W;

   logic [SLICE_W-1:0] p;
   logic [SLICE_W-1:0] g;
   logic [NGRP:0]      gc;
   logic               rc;

   assign p = a ^ b;
   assign g = a & b;

   // Each group ripples internally; when every bit propagates, the group
   // carry-out is taken straight from the group carry-in.
   always_comb begin
      s     = '0;
      gc    = '0;
      rc    = 1'b0;
      gc[0] = ci;
      for (int unsigned k = 0; k < NGRP; k++) begin
         rc = gc[k];
         for (int unsigned j = 0; j < GRP_W; j++) begin
            s[k*GRP_W + j] = p[k*GRP_W + j] ^ rc;
            rc             = g[k*GRP_W + j] | (p[k*GRP_W + j] & rc);
         end
         gc[k+1] = (&p[k*GRP_W +: GRP_W]) ? gc[k] : rc;
      end
   end

   assign co = gc[NGRP];

endmodule

// File: rtl/skip_add_seq.sv
// Two-requester, round-robin, byte-serial adder using one shared carry-skip slice.
// Define SKIP_ADD_SUB_EN to add the req_sub port (a - b via inverted b, carry-in 1).
module skip_add_seq
   import skip_add_seq_pkg::*;
#(
   parameter int unsigned NBYTES = 4
)
(
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NREQ-1:0]                      req_valid,
   output logic [NREQ-1:0]                      req_ready,
   input  logic [NREQ-1:0][SLICE_W*NBYTES-1:0]  req_a,
   input  logic [NREQ-1:0][SLICE_W*NBYTES-1:0]  req_b,
   input  logic [NREQ-1:0]                      req_ci,
`ifdef SKIP_ADD_SUB_EN
   input  logic [NREQ-1:0]                      req_sub,
`endif
   output logic                                 res_valid,
   input  logic                                 res_ready,
   output logic [SLICE_W*NBYTES-1:0]            res_sum,
   output logic                                 res_co,
   output logic                                 res_id
);

   localparam int unsigned W  = SLICE_W * NBYTES;
   localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   state_t               state;
   logic                 ptr;
   logic                 grant;
   logic                 accept;
   logic                 sub_sel;
   logic [W-1:0]         a_q;
   logic [W-1:0]         b_q;
   logic                 carry;
   logic [IW-1:0]        idx;
   logic [SLICE_W-1:0]   byte_a;
   logic [SLICE_W-1:0]   byte_b;
   logic [SLICE_W-1:0]   byte_s;
   logic                 byte_co;

   always_comb begin
      grant = ptr;
      if (req_valid[0] && !req_valid[1])
         grant = 1'b0;
      else if (req_valid[1] && !req_valid[0])
         grant = 1'b1;
      req_ready = '0;
      if (state == IDLE)
         req_ready[grant] = req_valid[grant];
      accept = |(req_valid & req_ready);
   end

`ifdef SKIP_ADD_SUB_EN
   assign sub_sel = req_sub[grant];
`else
   assign sub_sel = 1'b0;
`endif

   assign byte_a = a_q[int'(idx)*SLICE_W +: SLICE_W];
   assign byte_b = b_q[int'(idx)*SLICE_W +: SLICE_W];

   skip_slice8 u_slice (
      .a  (byte_a),
      .b  (byte_b),
      .ci (carry),
      .s  (byte_s),
      .co (byte_co)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         carry     <= 1'b0;
         idx       <= '0;
         res_valid <= 1'b0;
         res_sum   <= '0;
         res_co    <= 1'b0;
         res_id    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_q    <= req_a[grant];
                  b_q    <= sub_sel ? ~req_b[grant] : req_b[grant];
                  carry  <= sub_sel | req_ci[grant];
                  res_id <= grant;
                  idx    <= '0;
                  ptr    <= ~grant;
                  state  <= RUN;
               end
            end
            RUN: begin
               res_sum[int'(idx)*SLICE_W +: SLICE_W] <= byte_s;
               carry <= byte_co;
               idx   <= idx + 1'b1;
               if (idx == IW'(NBYTES - 1)) begin
                  res_co    <= byte_co;
                  res_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_skip_add_seq.sv
// Directed + random scoreboard bench for skip_add_seq (NBYTES=4).
module tb_skip_add_seq;
   import skip_add_seq_pkg::*;

   localparam int unsigned NBYTES = 4;
   localparam int unsigned W      = SLICE_W * NBYTES;

   logic                       clk = 1'b0;
   logic                       rst;
   logic [NREQ-1:0]            req_valid;
   logic [NREQ-1:0]            req_ready;
   logic [NREQ-1:0][W-1:0]     req_a;
   logic [NREQ-1:0][W-1:0]     req_b;
   logic [NREQ-1:0]            req_ci;
   logic [NREQ-1:0]            req_sub;
   logic                       res_valid;
   logic                       res_ready;
   logic [W-1:0]               res_sum;
   logic                       res_co;
   logic                       res_id;

   skip_add_seq #(.NBYTES(NBYTES)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ci    (req_ci),
`ifdef SKIP_ADD_SUB_EN
      .req_sub   (req_sub),
`endif
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_sum   (res_sum),
      .res_co    (res_co),
      .res_id    (res_id)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         co;
      logic         id;
   } exp_t;

   exp_t         sb[$];
   int unsigned  ncomp = 0;
   int unsigned  nfail = 0;
   int           cyc = 0;
   int           acc_cyc = 0;
   bit           busy = 0;
   bit           acc_seen = 0;
   logic         acc_id = 1'b0;
   logic         prev_rv = 1'b0;
   int           log_id[$];
   int           log_cyc[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncomp++;
      assert (obs === exp)
      else begin
         nfail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample handshakes 1ns after the input-change (negedge), then advance.
   task automatic step();
      exp_t         e;
      logic [W:0]   full;
      logic [W-1:0] bb;
      logic         cc;
      logic         sb_sub;
      int           g;
      #1;
      if (rst) begin
         sb.delete();
         busy = 0;
      end else begin
         chk("ready_legal", ((req_ready & ~req_valid) == 2'b00) && (req_ready != 2'b11), 1);
         if (busy) chk("ready_while_busy", req_ready, 2'b00);
         if (res_valid && !prev_rv) chk("latency", cyc - acc_cyc, NBYTES + 1);
         if (res_valid && res_ready) begin
            chk("result_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("res_sum", res_sum, e.sum);
               chk("res_co", res_co, e.co);
               chk("res_id", res_id, e.id);
            end
            busy = 0;
         end
         if (|(req_valid & req_ready)) begin
            g = req_ready[1] ? 1 : 0;
`ifdef SKIP_ADD_SUB_EN
            sb_sub = req_sub[g];
`else
            sb_sub = 1'b0;
`endif
            bb    = sb_sub ? ~req_b[g] : req_b[g];
            cc    = sb_sub ? 1'b1 : req_ci[g];
            full  = {1'b0, req_a[g]} + {1'b0, bb} + {{W{1'b0}}, cc};
            e.sum = full[W-1:0];
            e.co  = full[W];
            e.id  = g[0];
            sb.push_back(e);
            busy     = 1;
            acc_seen = 1;
            acc_id   = g[0];
            acc_cyc  = cyc;
            log_id.push_back(g);
            log_cyc.push_back(cyc);
         end
      end
      prev_rv = rst ? 1'b0 : res_valid;
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic wait_accept(input string tag);
      acc_seen = 0;
      for (int k = 0; k < 50 && !acc_seen; k++) step();
      if (!acc_seen) chk({tag, "_accept_timeout"}, acc_seen, 1);
   endtask

   task automatic drain(input string tag, input bit rnd_ready);
      for (int k = 0; k < 80 && busy; k++) begin
         res_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         step();
      end
      if (busy) chk({tag, "_drain_timeout"}, busy, 0);
      res_ready = 1'b1;
   endtask

   task automatic run_op(input int g, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic sub, input bit rnd_ready, input string tag);
      req_a[g]   = a;
      req_b[g]   = b;
      req_ci[g]  = ci;
      req_sub[g] = sub;
      req_valid  = 2'b00;
      req_valid[g] = 1'b1;
      wait_accept(tag);
      req_valid = 2'b00;
      drain(tag, rnd_ready);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [W-1:0] cap_sum;
   logic         cap_co;
   logic         cap_id;
   bit           seen_rv;

   initial begin
      rst       = 1'b1;
      req_valid = 2'b00;
      req_a     = '0;
      req_b     = '0;
      req_ci    = '0;
      req_sub   = '0;
      res_ready = 1'b1;
      @(negedge clk);
      step();
      step();
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_sum", res_sum, 0);
      chk("rst_res_co", res_co, 0);
      chk("rst_res_id", res_id, 0);
      req_valid = 2'b10;
      #1 chk("rst_ready_comb", req_ready, 2'b10);
      req_valid = 2'b00;
      step();
      rst = 1'b0;
      step();

      run_op(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0, "inc_byte");
      chk("inc_byte_sum", res_sum, 32'h0000_0100);
      chk("inc_byte_co", res_co, 0);
      chk("inc_byte_id", res_id, 0);
      run_op(1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0, "full_ripple");
      chk("full_ripple_sum", res_sum, 32'h0000_0000);
      chk("full_ripple_co", res_co, 1);
      run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, "max_max");
      run_op(1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 0, "top_carry");

      // Both requesters valid from reset, result taken immediately.
      rst       = 1'b1;
      req_a     = {32'h1234_5678, 32'h0F0F_0F0F};
      req_b     = {32'h1111_1111, 32'hF0F0_F0F1};
      req_ci    = 2'b10;
      req_valid = 2'b11;
      step();
      step();
      rst = 1'b0;
      log_id.delete();
      log_cyc.delete();
      for (int k = 0; k < 60 && log_id.size() < 4; k++) step();
      req_valid = 2'b00;
      drain("rr", 0);
      chk("rr_accepts", log_id.size(), 4);
      if (log_id.size() >= 4) begin
         for (int i = 0; i < 4; i++) chk("rr_order", log_id[i], i % 2);
         for (int i = 1; i < 4; i++) chk("rr_interval", log_cyc[i] - log_cyc[i-1], NBYTES + 2);
      end

      // Result back-pressured for 10 cycles while both requesters stay valid.
      res_ready = 1'b0;
      req_a     = {32'hDEAD_BEEF, 32'h0123_4567};
      req_b     = {32'h0000_0001, 32'h89AB_CDEF};
      req_ci    = 2'b01;
      req_valid = 2'b11;
      wait_accept("hold");
      chk("hold_first_grant", acc_id, 0);
      seen_rv = 0;
      for (int k = 0; k < 20 && !seen_rv; k++) begin
         step();
         seen_rv = res_valid;
      end
      chk("hold_res_valid", seen_rv, 1);
      cap_sum = res_sum;
      cap_co  = res_co;
      cap_id  = res_id;
      acc_seen = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         chk("hold_valid", res_valid, 1);
         chk("hold_sum", res_sum, cap_sum);
         chk("hold_co", res_co, cap_co);
         chk("hold_id", res_id, cap_id);
      end
      chk("hold_no_accept", acc_seen, 0);
      res_ready = 1'b1;
      step();
      wait_accept("post_hold");
      chk("post_hold_grant", acc_id, 1);
      req_valid = 2'b00;
      drain("post_hold", 0);

      // Reset in the second RUN cycle aborts the operation.
      req_a[0]  = 32'h0000_FFFF;
      req_b[0]  = 32'h0000_0001;
      req_ci[0] = 1'b0;
      req_valid = 2'b01;
      wait_accept("abort");
      req_valid = 2'b00;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("abort_no_valid", res_valid, 0);
         step();
      end
      req_valid = 2'b11;
      #1 chk("abort_ptr_reset", req_ready, 2'b01);
      wait_accept("post_abort");
      chk("post_abort_grant", acc_id, 0);
      req_valid = 2'b00;
      drain("post_abort", 0);

`ifdef SKIP_ADD_SUB_EN
      run_op(0, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 0, "sub_neg");
      chk("sub_neg_sum", res_sum, 32'hFFFF_FFFE);
      chk("sub_neg_co", res_co, 0);
      run_op(1, 32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 0, "sub_pos");
      chk("sub_pos_sum", res_sum, 32'h0000_0002);
      chk("sub_pos_co", res_co, 1);
      for (int i = 0; i < 1000; i++)
         run_op(int'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1, "rand");
`else
      for (int i = 0; i < 60; i++)
         run_op(int'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
                1'b0, 1, "rand");
`endif

      chk("sb_empty_end", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
      $finish;
   end

endmodule
